hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline sequencer for the 16-bit, 8-register, 5-stage pipeline. Drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register controls from hazard information.
- Detects load-use RAW hazards and inserts a bubble into ID/EX.
- Selects operand forwarding sources for the ID stage.
- Flushes wrong-path instructions on a taken branch resolved in EX.
- Freezes the whole pipeline while data memory is busy, with a watchdog timeout.

Parameters:
REG_AW, 3, register address width
CNT_W, 8, width of memory-wait counter
MEM_TIMEOUT, 200, max consecutive mem_busy cycles before error (must be < 2^CNT_W)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
id_src1  in  REG_AW  ID-stage operand 1 register
id_src1_used  in  1  operand 1 is read
id_src2  in  REG_AW  ID-stage operand 2 register (also store data)
id_src2_used  in  1  operand 2 is read
ex_wb_en  in  1  EX-stage instr writes back
ex_wb_dest  in  REG_AW  EX-stage destination
ex_is_load  in  1  EX-stage instr is a load
mem_wb_en  in  1  MEM-stage instr writes back
mem_wb_dest  in  REG_AW  MEM-stage destination
wb_wb_en  in  1  WB-stage instr writes back
wb_wb_dest  in  REG_AW  WB-stage destination
branch_taken  in  1  taken branch resolved in EX
mem_busy  in  1  data memory not ready
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID capture enable
if_id_flush  out  1  IF/ID clear (priority over enable)
id_ex_en  out  1  ID/EX capture enable
id_ex_bubble  out  1  ID/EX clear to NOP (priority over enable)
ex_mem_en  out  1  EX/MEM capture enable
mem_wb_en_o  out  1  MEM/WB capture enable
fwd1_sel  out  2  operand 1 source: 00 regfile, 01 EX result, 10 MEM result, 11 WB result
fwd2_sel  out  2  operand 2 source, same encoding
mem_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (synchronous, active-high, on clock): state <= RUN, wait_cnt <= 0, mem_timeout <= 0.
- While reset is high, outputs are forced combinationally: all enables 0, if_id_flush=1, id_ex_bubble=1, fwd*_sel=00.
- Reset mid-wait aborts the wait; the first cycle after reset is RUN.
- States: RUN, MEM_WAIT, ERROR. Outputs are combinational from state + inputs; zero-cycle response.
- Register 0 reads as zero: a destination of 0 never matches (no hazard, no forward).
- Match definitions:
  - matchX(s) = used & wb_en_X & dest_X==s & s!=0, for X = EX, MEM, WB.
- Forwarding: priority EX > MEM > WB > regfile, per operand, independent of state.
  - An EX match with ex_is_load=1 does not select 01; it produces a load-use hazard.
  - During a load-use hazard fwd*_sel is don't-care-but-defined: computed as if the load did not match.
- RUN, evaluated in priority order:
  1. mem_busy=1: freeze. All enables 0, no flush/bubble. Next state MEM_WAIT, wait_cnt <= 1.
  2. branch_taken=1: pc_en=1, if_id_flush=1, id_ex_bubble=1, ex_mem_en=1, mem_wb_en_o=1. Load-use is ignored, since the ID instruction is discarded.
  3. Load-use (ex_is_load & EX match on either used operand):
     - pc_en=0, if_id_en=0, id_ex_bubble=1, ex_mem_en=1, mem_wb_en_o=1.
     - Exactly one bubble; next cycle the load is in MEM and forwards via 10.
  4. Otherwise: all enables 1, no flush/bubble.
- MEM_WAIT:
  - mem_busy=1: all enables 0, no flush/bubble; wait_cnt increments.
  - If wait_cnt==MEM_TIMEOUT, next state ERROR and mem_timeout <= 1.
  - mem_busy=0: this cycle behaves exactly as RUN cases 2-4 (the EX instruction was held, so a branch_taken or load-use present on entry is still applied). Next state RUN, wait_cnt <= 0.
- ERROR: all enables 0, flush/bubble 0, mem_timeout=1. Only reset exits.
- Simultaneous mem_busy + branch_taken: freeze wins; the branch applies on the release cycle.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined: adds outputs stall_cycles[15:0] and flush_count[15:0], both saturating at 0xFFFF and cleared by reset.
  - stall_cycles increments on every cycle with pc_en=0 outside reset and ERROR.
  - flush_count increments on every cycle with if_id_flush=1 outside reset.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset held 3 cycles, then released -> during reset if_id_flush=1, id_ex_bubble=1, all enables 0; first released cycle all enables 1.
- ex_is_load=1, ex_wb_en=1, ex_wb_dest=3, id_src2=3 used -> one cycle pc_en=0, if_id_en=0, id_ex_bubble=1. Next cycle with mem_wb_dest=3: fwd2_sel=10, all enables 1.
- ex_wb_dest=5 (non-load), mem_wb_dest=5, wb_wb_dest=5, id_src1=5 -> fwd1_sel=01. Same with dest 0 and id_src1=0 -> fwd1_sel=00, no stall.
- branch_taken=1 together with a load-use match -> if_id_flush=1, id_ex_bubble=1, pc_en=1 for one cycle; no extra stall cycle.
- mem_busy and branch_taken rise together, mem_busy held 4 cycles -> 4 frozen cycles (all enables 0), then flush cycle with pc_en=1, if_id_flush=1.
- MEM_TIMEOUT=4, mem_busy held high -> mem_timeout=1 after the 4th wait cycle; it stays 1 after mem_busy drops, until reset. With HAZ_PERF_CNT_EN, stall_cycles=4.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline sequencer for the 16-bit, 8-register, 5-stage pipeline:
//            load-use bubbles, operand forwarding, branch flush, and a memory
//            freeze with watchdog. Optional perf counters via HAZ_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_AW      = 3,
  parameter int CNT_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_src1,
  input  logic              id_src1_used,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_src2_used,
  input  logic              ex_wb_en,
  input  logic [REG_AW-1:0] ex_wb_dest,
  input  logic              ex_is_load,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] mem_wb_dest,
  input  logic              wb_wb_en,
  input  logic [REG_AW-1:0] wb_wb_dest,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_bubble,
  output logic              ex_mem_en,
  output logic              mem_wb_en_o,
  output logic [1:0]        fwd1_sel,
  output logic [1:0]        fwd2_sel,
  output logic              mem_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_mem_timeout;

  logic             w_ex_m1, w_mem_m1, w_wb_m1;
  logic             w_ex_m2, w_mem_m2, w_wb_m2;
  logic             w_load_use;
  logic [CNT_W-1:0] w_cnt_next;

  // Register 0 is hard-wired zero, so it never takes part in a match.
  assign w_ex_m1  = id_src1_used & ex_wb_en  & (ex_wb_dest  == id_src1) & (id_src1 != '0);
  assign w_mem_m1 = id_src1_used & mem_wb_en & (mem_wb_dest == id_src1) & (id_src1 != '0);
  assign w_wb_m1  = id_src1_used & wb_wb_en  & (wb_wb_dest  == id_src1) & (id_src1 != '0);
  assign w_ex_m2  = id_src2_used & ex_wb_en  & (ex_wb_dest  == id_src2) & (id_src2 != '0);
  assign w_mem_m2 = id_src2_used & mem_wb_en & (mem_wb_dest == id_src2) & (id_src2 != '0);
  assign w_wb_m2  = id_src2_used & wb_wb_en  & (wb_wb_dest  == id_src2) & (id_src2 != '0);

  assign w_load_use = ex_is_load & (w_ex_m1 | w_ex_m2);
  assign w_cnt_next = r_wait_cnt + c_one;

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en_o  = 1'b0;

    // A load in EX cannot forward yet; fall through to older stages.
    if (w_ex_m1 && !ex_is_load) fwd1_sel = 2'b01;
    else if (w_mem_m1)          fwd1_sel = 2'b10;
    else if (w_wb_m1)           fwd1_sel = 2'b11;
    else                        fwd1_sel = 2'b00;

    if (w_ex_m2 && !ex_is_load) fwd2_sel = 2'b01;
    else if (w_mem_m2)          fwd2_sel = 2'b10;
    else if (w_wb_m2)           fwd2_sel = 2'b11;
    else                        fwd2_sel = 2'b00;

    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      fwd1_sel     = 2'b00;
      fwd2_sel     = 2'b00;
    end else begin
      case (r_state)
        ST_RUN, ST_MEM_WAIT: begin
          // The EX instruction was held during a wait, so the release cycle
          // resolves exactly like a normal running cycle.
          if (mem_busy) begin
            pc_en = 1'b0;
          end else if (branch_taken) begin
            pc_en        = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_en    = 1'b1;
            mem_wb_en_o  = 1'b1;
          end else if (w_load_use) begin
            id_ex_bubble = 1'b1;
            ex_mem_en    = 1'b1;
            mem_wb_en_o  = 1'b1;
          end else begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en_o = 1'b1;
          end
        end
        default: pc_en = 1'b0;
      endcase
    end
  end

  assign mem_timeout = r_mem_timeout & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (mem_busy) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= c_one;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_busy) begin
            r_wait_cnt <= w_cnt_next;
            if (w_cnt_next >= c_timeout) begin
              r_state       <= ST_ERROR;
              r_mem_timeout <= 1'b1;
            end
          end else begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end
        end
        ST_ERROR: r_state <= ST_ERROR;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && r_state != ST_ERROR && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (if_id_flush && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl: directed vectors, corner
//            sequences and randomized traffic against a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int T = 4;

  typedef struct packed {
    logic       rst;
    logic [2:0] s1;  logic u1;
    logic [2:0] s2;  logic u2;
    logic       exen; logic [2:0] exd; logic ld;
    logic       men;  logic [2:0] md;
    logic       wen;  logic [2:0] wd;
    logic       br;
    logic       busy;
  } vin_t;

  typedef struct {
    string       name;
    vin_t        in;
    logic [11:0] exp;
  } vec_t;

  // Control groups: {pc, if_id_en, flush, id_ex_en, bubble, ex_mem, mem_wb}
  localparam logic [6:0] C_NORM = 7'b1101011;
  localparam logic [6:0] C_FRZ  = 7'b0000000;
  localparam logic [6:0] C_BR   = 7'b1010111;
  localparam logic [6:0] C_LU   = 7'b0000111;
  localparam logic [6:0] C_RST  = 7'b0010100;

  logic clock = 1'b0;
  logic reset;
  logic [2:0] id_src1, id_src2, ex_wb_dest, mem_wb_dest, wb_wb_dest;
  logic id_src1_used, id_src2_used, ex_wb_en, ex_is_load, mem_wb_en, wb_wb_en;
  logic branch_taken, mem_busy;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_en_o;
  logic [1:0] fwd1_sel, fwd2_sel;
  logic mem_timeout;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: consecutive busy cycles, sticky error, perf counts.
  int m_run = 0;
  bit m_err = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clock = ~clock;

  hazard_ctrl #(.REG_AW(3), .CNT_W(8), .MEM_TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used),
    .ex_wb_en(ex_wb_en), .ex_wb_dest(ex_wb_dest), .ex_is_load(ex_is_load),
    .mem_wb_en(mem_wb_en), .mem_wb_dest(mem_wb_dest),
    .wb_wb_en(wb_wb_en), .wb_wb_dest(wb_wb_dest),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
    .ex_mem_en(ex_mem_en), .mem_wb_en_o(mem_wb_en_o),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .mem_timeout(mem_timeout)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  function automatic vin_t mk(logic [2:0] s1, logic u1, logic [2:0] s2, logic u2,
                              logic exen, logic [2:0] exd, logic ld,
                              logic men, logic [2:0] md, logic wen, logic [2:0] wd,
                              logic br, logic busy);
    vin_t v;
    v.rst = 1'b0; v.s1 = s1; v.u1 = u1; v.s2 = s2; v.u2 = u2;
    v.exen = exen; v.exd = exd; v.ld = ld; v.men = men; v.md = md;
    v.wen = wen; v.wd = wd; v.br = br; v.busy = busy;
    return v;
  endfunction

  // Newest producer wins; a load in EX is skipped and older stages are tried.
  function automatic logic [1:0] src_of(vin_t v, logic [2:0] s, logic used);
    if (!used || s == 3'd0) return 2'b00;
    if (v.exen && v.exd == s && !v.ld) return 2'b01;
    if (v.men && v.md == s) return 2'b10;
    if (v.wen && v.wd == s) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [11:0] model(vin_t v);
    logic [6:0] c;
    logic lu;
    lu = v.ld && v.exen &&
         ((v.u1 && v.s1 != 0 && v.exd == v.s1) || (v.u2 && v.s2 != 0 && v.exd == v.s2));
    if (v.rst) return {C_RST, 4'b0000, 1'b0};
    if (m_err)       c = C_FRZ;
    else if (v.busy) c = C_FRZ;
    else if (v.br)   c = C_BR;
    else if (lu)     c = C_LU;
    else             c = C_NORM;
    return {c, src_of(v, v.s1, v.u1), src_of(v, v.s2, v.u2), m_err};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vin_t v);
    reset = v.rst;
    id_src1 = v.s1; id_src1_used = v.u1; id_src2 = v.s2; id_src2_used = v.u2;
    ex_wb_en = v.exen; ex_wb_dest = v.exd; ex_is_load = v.ld;
    mem_wb_en = v.men; mem_wb_dest = v.md; wb_wb_en = v.wen; wb_wb_dest = v.wd;
    branch_taken = v.br; mem_busy = v.busy;
  endtask

  // One clock cycle: drive at negedge, compare before the next posedge,
  // then advance the model to what the next cycle should see.
  task automatic step(string name, vin_t v, bit has_exp, logic [11:0] exp);
    logic [11:0] m, act;
    @(negedge clock);
    drive(v);
    #2;
    m = model(v);
    act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
           mem_wb_en_o, fwd1_sel, fwd2_sel, mem_timeout};
    if (has_exp) chk({name, "/spec"}, 32'(act), 32'(exp));
    chk({name, "/model"}, 32'(act), 32'(m));
`ifdef HAZ_PERF_CNT_EN
    if (!v.rst) begin
      chk({name, "/stall"}, 32'(stall_cycles), 32'(m_stall));
      chk({name, "/flush"}, 32'(flush_count), 32'(m_flush));
    end
`endif
    if (v.rst) begin
      m_err = 1'b0; m_run = 0; m_stall = 0; m_flush = 0;
    end else if (!m_err) begin
      if (!m[11] && m_stall < 65535) m_stall++;
      if (m[9] && m_flush < 65535) m_flush++;
      if (v.busy) begin
        m_run++;
        if (m_run >= T) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  vec_t tbl[11];
  vin_t v, idle, rst_v, lu_v;

  initial begin
    idle = mk(3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    rst_v = idle; rst_v.rst = 1'b1;
    drive(rst_v);

    tbl[0]  = '{"idle",      mk(1,1,2,1, 0,0,0, 0,0, 0,0, 0,0), {C_NORM, 2'b00, 2'b00, 1'b0}};
    tbl[1]  = '{"fwd_ex",    mk(5,1,0,1, 1,5,0, 1,5, 1,5, 0,0), {C_NORM, 2'b01, 2'b00, 1'b0}};
    tbl[2]  = '{"dest0",     mk(0,1,0,1, 1,0,0, 1,0, 1,0, 0,0), {C_NORM, 2'b00, 2'b00, 1'b0}};
    tbl[3]  = '{"fwd_mem",   mk(1,1,2,1, 1,6,0, 1,2, 1,2, 0,0), {C_NORM, 2'b00, 2'b10, 1'b0}};
    tbl[4]  = '{"fwd_wb",    mk(7,1,3,1, 1,6,0, 1,5, 1,7, 0,0), {C_NORM, 2'b11, 2'b00, 1'b0}};
    tbl[5]  = '{"unused",    mk(5,0,5,0, 1,5,0, 1,5, 1,5, 0,0), {C_NORM, 2'b00, 2'b00, 1'b0}};
    tbl[6]  = '{"lu_op2",    mk(1,1,3,1, 1,3,1, 0,0, 0,0, 0,0), {C_LU,   2'b00, 2'b00, 1'b0}};
    tbl[7]  = '{"lu_memfb",  mk(4,1,0,0, 1,4,1, 1,4, 0,0, 0,0), {C_LU,   2'b10, 2'b00, 1'b0}};
    tbl[8]  = '{"br_lu",     mk(1,1,3,1, 1,3,1, 0,0, 0,0, 1,0), {C_BR,   2'b00, 2'b00, 1'b0}};
    tbl[9]  = '{"br_fwd",    mk(5,1,0,0, 1,5,0, 0,0, 0,0, 1,0), {C_BR,   2'b01, 2'b00, 1'b0}};
    tbl[10] = '{"lu_r0",     mk(0,1,0,1, 1,0,1, 0,0, 0,0, 0,0), {C_NORM, 2'b00, 2'b00, 1'b0}};

    // Reset held three cycles, then the first free-running cycle.
    for (int i = 0; i < 3; i++) begin
      v = tbl[6].in; v.rst = 1'b1;
      step("reset", v, 1'b1, {C_RST, 4'b0000, 1'b0});
    end
    step("post_reset", idle, 1'b1, {C_NORM, 4'b0000, 1'b0});

    for (int i = 0; i < 11; i++) step(tbl[i].name, tbl[i].in, 1'b1, tbl[i].exp);

    // Load-use: exactly one bubble, then the load forwards from MEM.
    lu_v = mk(1,0,3,1, 1,3,1, 0,0, 0,0, 0,0);
    step("lu_stall", lu_v, 1'b1, {C_LU, 2'b00, 2'b00, 1'b0});
    step("lu_after", mk(1,0,3,1, 0,0,0, 1,3, 0,0, 0,0), 1'b1, {C_NORM, 2'b00, 2'b10, 1'b0});

    // Freeze wins over a simultaneous branch; branch resolves on release.
    for (int i = 0; i < 3; i++)
      step("busy_br_frz", mk(0,0,0,0, 0,0,0, 0,0, 0,0, 1,1), 1'b1, {C_FRZ, 4'b0000, 1'b0});
    step("busy_br_rel", mk(0,0,0,0, 0,0,0, 0,0, 0,0, 1,0), 1'b1, {C_BR, 4'b0000, 1'b0});
    step("busy_br_next", idle, 1'b1, {C_NORM, 4'b0000, 1'b0});

    // Load-use present on wait entry is still applied on release.
    v = lu_v; v.busy = 1'b1;
    step("busy_lu_frz", v, 1'b1, {C_FRZ, 4'b0000, 1'b0});
    step("busy_lu_frz", v, 1'b1, {C_FRZ, 4'b0000, 1'b0});
    step("busy_lu_rel", lu_v, 1'b1, {C_LU, 4'b0000, 1'b0});

    // Watchdog: T busy cycles, then sticky error until reset.
    step("to_reset", rst_v, 1'b1, {C_RST, 4'b0000, 1'b0});
    v = idle; v.busy = 1'b1;
    for (int i = 0; i < T; i++) step("to_wait", v, 1'b1, {C_FRZ, 4'b0000, 1'b0});
    step("to_err", v, 1'b1, {C_FRZ, 4'b0000, 1'b1});
    step("to_sticky", idle, 1'b1, {C_FRZ, 4'b0000, 1'b1});
    step("to_sticky_br", mk(0,0,0,0, 0,0,0, 0,0, 0,0, 1,0), 1'b1, {C_FRZ, 4'b0000, 1'b1});
`ifdef HAZ_PERF_CNT_EN
    chk("to_stall_cnt", 32'(stall_cycles), 32'd4);
`endif
    step("to_clear", rst_v, 1'b1, {C_RST, 4'b0000, 1'b0});
    step("to_cleared", idle, 1'b1, {C_NORM, 4'b0000, 1'b0});

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      v.rst  = ($urandom_range(0, 39) == 0);
      v.s1   = 3'($urandom_range(0, 7)); v.u1 = 1'($urandom);
      v.s2   = 3'($urandom_range(0, 7)); v.u2 = 1'($urandom);
      v.exen = 1'($urandom); v.exd = 3'($urandom_range(0, 7));
      v.ld   = ($urandom_range(0, 2) == 0);
      v.men  = 1'($urandom); v.md = 3'($urandom_range(0, 7));
      v.wen  = 1'($urandom); v.wd = 3'($urandom_range(0, 7));
      v.br   = ($urandom_range(0, 5) == 0);
      v.busy = ($urandom_range(0, 7) == 0);
      step("random", v, 1'b0, 12'h000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
